// File: rtl/fp_arith_seq.sv
// fp_arith_seq - multi-cycle floating-point add/multiply unit.
//
// Format {sign, exp[EXP_W], frac[MAN_W]}, bias 2^(EXP_W-1)-1, hidden leading 1.
// An exp field of 0 is zero. There are no denormals, infinities or NaN.
// Flow: IDLE -> CALC -> NORM (one left shift per cycle) -> PACK -> DONE.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake; op, a and b are sampled at accept
//   op                   0 = add, 1 = multiply
//   out_valid/out_ready  result handshake; result, ovf and unf are held until taken
//   ovf / unf            overflow (saturated to max finite) / underflow (flushed to 0)
//
// Optional feature macro: FP_ROUND_NEAREST_EN
//   Defined   : PACK rounds to nearest-even using guard and sticky.
//   Undefined : PACK truncates.
module fp_arith_seq #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     ovf,
    output logic                     unf
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int L  = MAN_W + 4;          // hidden, frac, guard, round, sticky
    localparam int EW = EXP_W + 3;          // signed working exponent
    localparam int XW = 1 << EXP_W;         // alignment headroom, covers any exp difference
    localparam int PW = 2 * MAN_W + 2;      // product width

    localparam logic signed [EW-1:0] ONE_S   = EW'(1);
    localparam logic signed [EW-1:0] BIAS_S  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_TOP = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, CALC, NORM, PACK, DONE} state_t;

    state_t state, nstate;

    logic [W-1:0]          a_q, b_q;
    logic                  op_q;
    logic                  sign_q;
    logic                  byp_q;
    logic signed [EW-1:0]  exp_q;
    logic [L-1:0]          m_q;

    function automatic logic signed [EW-1:0] xe(input logic [EXP_W-1:0] e);
        return {{(EW - EXP_W){1'b0}}, e};
    endfunction

    // ---------------- CALC datapath ----------------
    logic [W-1:0]          big, sml;
    logic [EXP_W-1:0]      d;
    logic [L-1:0]          ml, ms;
    logic [L+XW-1:0]       ext;
    logic [L:0]            sum;
    logic [MAN_W:0]        ma, mb;
    logic [PW-1:0]         prod;
    logic [PW+1:0]         pe;
    logic                  a_zero, b_zero;
    logic [L-1:0]          c_m;
    logic signed [EW-1:0]  c_e;
    logic                  c_s, c_byp;
    logic [W-1:0]          c_word;

    always_comb begin
        a_zero = (a_q[W-2:MAN_W] == '0);
        b_zero = (b_q[W-2:MAN_W] == '0);

        // {exp, frac} ordered as an unsigned word is a magnitude compare
        big = (a_q[W-2:0] >= b_q[W-2:0]) ? a_q : b_q;
        sml = (a_q[W-2:0] >= b_q[W-2:0]) ? b_q : a_q;
        d   = big[W-2:MAN_W] - sml[W-2:MAN_W];
        ml  = {1'b1, big[MAN_W-1:0], 3'b000};
        ext = {1'b1, sml[MAN_W-1:0], 3'b000, {XW{1'b0}}} >> d;
        // keep hidden..round, fold everything below into sticky
        ms  = {ext[L+XW-1:XW+1], |ext[XW:0]};
        sum = (big[W-1] == sml[W-1]) ? ({1'b0, ml} + {1'b0, ms})
                                     : ({1'b0, ml} - {1'b0, ms});

        ma   = {1'b1, a_q[MAN_W-1:0]};
        mb   = {1'b1, b_q[MAN_W-1:0]};
        prod = {{(MAN_W+1){1'b0}}, ma} * {{(MAN_W+1){1'b0}}, mb};
        // product in [1,4): align leading 1 to the top, tail collapses into sticky
        pe   = prod[PW-1] ? {prod, 2'b00} : {prod[PW-2:0], 3'b000};

        c_m    = '0;
        c_e    = '0;
        c_s    = 1'b0;
        c_byp  = 1'b0;
        c_word = a_q;

        if (!op_q) begin
            if (a_zero && b_zero) begin
                c_byp = 1'b0;
            end else if (a_zero) begin
                c_byp  = 1'b1;
                c_word = b_q;
            end else if (b_zero) begin
                c_byp  = 1'b1;
                c_word = a_q;
            end else begin
                c_e = xe(big[W-2:MAN_W]);
                if (sum[L]) begin
                    c_m = {sum[L:2], sum[1] | sum[0]};
                    c_e = c_e + ONE_S;
                end else begin
                    c_m = sum[L-1:0];
                end
                // exact cancellation yields +0
                c_s = (sum == '0) ? 1'b0 : big[W-1];
            end
        end else if (!(a_zero || b_zero)) begin
            c_s = a_q[W-1] ^ b_q[W-1];
            c_e = xe(a_q[W-2:MAN_W]) + xe(b_q[W-2:MAN_W]) - BIAS_S
                  + (prod[PW-1] ? ONE_S : '0);
            c_m = {pe[PW+1 -: L-1], |pe[MAN_W:0]};
        end
    end

    // ---------------- PACK datapath ----------------
    logic [MAN_W-1:0]      frac_p;
    logic signed [EW-1:0]  exp_p;
    logic [W-1:0]          pk_result;
    logic                  pk_ovf, pk_unf;

`ifdef FP_ROUND_NEAREST_EN
    logic [MAN_W+1:0]      mant_rnd;
    logic                  rnd_up;

    always_comb begin
        // guard set and (round | sticky | lsb) -> round up (ties to even)
        rnd_up   = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
        mant_rnd = {1'b0, m_q[L-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        frac_p   = mant_rnd[MAN_W+1] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
        exp_p    = mant_rnd[MAN_W+1] ? (exp_q + ONE_S) : exp_q;
    end
`else
    assign frac_p = m_q[L-2:3];
    assign exp_p  = exp_q;
`endif

    always_comb begin
        pk_result = '0;
        pk_ovf    = 1'b0;
        pk_unf    = 1'b0;
        if (byp_q) begin
            pk_result = a_q;
        end else if (m_q[L-1]) begin
            // a clear hidden bit here can only mean an exact-zero mantissa
            if (exp_p > EXP_TOP) begin
                pk_result = {sign_q, {(W-1){1'b1}}};
                pk_ovf    = 1'b1;
            end else if (exp_p < ONE_S) begin
                pk_unf    = 1'b1;
            end else begin
                pk_result = {sign_q, exp_p[EXP_W-1:0], frac_p};
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate   = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nstate = CALC;
            end
            CALC: nstate = (c_byp || c_m == '0 || c_m[L-1]) ? PACK : NORM;
            // leave as soon as the bit about to become MSB is set
            NORM: if (m_q[L-2]) nstate = PACK;
            PACK: nstate = DONE;
            DONE: if (out_valid && out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            sign_q    <= 1'b0;
            byp_q     <= 1'b0;
            exp_q     <= '0;
            m_q       <= '0;
            result    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op;
                    end
                end
                CALC: begin
                    m_q    <= c_m;
                    exp_q  <= c_e;
                    sign_q <= c_s;
                    byp_q  <= c_byp;
                    a_q    <= c_word;    // bypass word travels in a_q to PACK
                end
                NORM: begin
                    m_q   <= m_q << 1;
                    exp_q <= exp_q - ONE_S;
                end
                PACK: begin
                    result <= pk_result;
                    ovf    <= pk_ovf;
                    unf    <= pk_unf;
                end
                DONE: begin
                    // raised one edge after the result registers load
                    if (!out_valid)     out_valid <= 1'b1;
                    else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_arith_seq.sv
module tb_fp_arith_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       ovf;
    logic       unf;

    int vectors     = 0;
    int miscompares = 0;

    fp_arith_seq #(.EXP_W(3), .MAN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for out_valid with a cycle budget; lat counts edges after accept.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] er,
                          input logic eo, input logic eu, input int el);
        int lat;
        @(negedge clk);
        op = o; a = av; b = bv; in_valid = 1'b1;
        chk({tag, ".in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk({tag, ".latency"}, lat, el);
        chk({tag, ".result"}, {24'b0, result}, {24'b0, er});
        chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, eo});
        chk({tag, ".unf"}, {31'b0, unf}, {31'b0, eu});
        chk({tag, ".in_ready_busy"}, {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".in_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [7:0] exp_rnd1;
        logic [7:0] exp_rnd2;
`ifdef FP_ROUND_NEAREST_EN
        exp_rnd1 = 8'h41;
        exp_rnd2 = 8'h5E;
`else
        exp_rnd1 = 8'h40;
        exp_rnd2 = 8'h5D;
`endif
        rst = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset.in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset.result",    {24'b0, result},    32'd0);
        chk("reset.ovf",       {31'b0, ovf},       32'd0);
        chk("reset.unf",       {31'b0, unf},       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_2p0_1p5",    1'b0, 8'h40, 8'h38, 8'h4C, 1'b0, 1'b0, 3);
        run_op("mul_3p0_m2p0",   1'b1, 8'h48, 8'hC0, 8'hD8, 1'b0, 1'b0, 3);
        run_op("add_norm3",      1'b0, 8'h48, 8'hC6, 8'h10, 1'b0, 1'b0, 6);
        run_op("add_cancel",     1'b0, 8'h48, 8'hC8, 8'h00, 1'b0, 1'b0, 3);
        run_op("mul_underflow",  1'b1, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 3);
        run_op("mul_round",      1'b1, 8'h37, 8'h37, exp_rnd1, 1'b0, 1'b0, 3);
        run_op("add_sticky",     1'b0, 8'h60, 8'hA1, exp_rnd2, 1'b0, 1'b0, 4);
        run_op("add_carry",      1'b0, 8'h4C, 8'h4C, 8'h5C, 1'b0, 1'b0, 3);
        run_op("add_zero_a",     1'b0, 8'h00, 8'hC6, 8'hC6, 1'b0, 1'b0, 3);
        run_op("add_zero_frac",  1'b0, 8'h05, 8'h38, 8'h38, 1'b0, 1'b0, 3);
        run_op("mul_by_zero",    1'b1, 8'h48, 8'h80, 8'h00, 1'b0, 1'b0, 3);
        run_op("add_overflow",   1'b0, 8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0, 3);

        // Backpressure: result held, busy, and a second request ignored.
        @(negedge clk);
        op = 1'b0; a = 8'h40; b = 8'h38; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 1'b1; a = 8'h7F; b = 8'h7F;
        wait_valid(lat);
        chk("hold.latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold.out_valid", {31'b0, out_valid}, 32'd1);
            chk("hold.result",    {24'b0, result},    32'h4C);
            chk("hold.in_ready",  {31'b0, in_ready},  32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold.release", {31'b0, out_valid}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("hold.no_phantom", {31'b0, out_valid}, 32'd0);

        run_op("mul_overflow", 1'b1, 8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0, 3);

        // Reset while normalising; previous held result was 0x7F with ovf=1.
        @(negedge clk);
        op = 1'b0; a = 8'h48; b = 8'hC6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst.in_ready",  {31'b0, in_ready},  32'd1);
        chk("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst.result",    {24'b0, result},    32'd0);
        chk("midrst.ovf",       {31'b0, ovf},       32'd0);
        chk("midrst.unf",       {31'b0, unf},       32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst_mul", 1'b1, 8'h48, 8'hC0, 8'hD8, 1'b0, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
